// File: rtl/apb_uart_slave_if.sv
`default_nettype none

//============================================================================
// Module      : apb_uart_slave_if
// Description : APB3 slave front-end for the apb_uart core. Turns a
//               PSEL/PENABLE transfer into one level-held core strobe
//               (TX_detect, RX_detect, config_write_detect or
//               config_read_detect). It then waits for core_ready and
//               returns a single-cycle PREADY with PRDATA/PSLVERR. It does
//               not accept a new transfer until core_ready has fallen.
//
// Ports       : PCLK, PRESET            - clock, synchronous active-high reset
//               PSEL/PENABLE/PWRITE     - APB control
//               PADDR, PWDATA           - APB address / write data
//               PRDATA, PREADY, PSLVERR - registered APB response
//               write_data_in           - latched PWDATA to the core
//               config_address          - latched PADDR to the core
//               TX_detect, RX_detect,
//               config_write_detect,
//               config_read_detect      - one-hot core command strobes
//               core_read_data          - core read data
//               core_ready, core_error  - core handshake
//
// Options     : APB_UART_TIMEOUT_EN - when defined, adds a BUSY watchdog
//               that errors out after TIMEOUT_CYCLES without core_ready.
//
// Revision    : 1.0 - initial release
//============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module apb_uart_slave_if #(
    parameter int                    DATA_WIDTH     = `DATA_WIDTH,
    parameter int                    ADDR_WIDTH     = `ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TX_ADDR        = 'h00,
    parameter logic [ADDR_WIDTH-1:0] RX_ADDR        = 'h04,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] write_data_in,
    output logic [ADDR_WIDTH-1:0] config_address,
    output logic                  TX_detect,
    output logic                  RX_detect,
    output logic                  config_write_detect,
    output logic                  config_read_detect,
    input  logic [DATA_WIDTH-1:0] core_read_data,
    input  logic                  core_ready,
    input  logic                  core_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Strobe vector bit order: {TX, RX, config write, config read}
    localparam logic [3:0] c_STB_NONE = 4'b0000;
    localparam logic [3:0] c_STB_TX   = 4'b1000;
    localparam logic [3:0] c_STB_RX   = 4'b0100;
    localparam logic [3:0] c_STB_CW   = 4'b0010;
    localparam logic [3:0] c_STB_CR   = 4'b0001;

    state_t                r_state;
    state_t                w_state_nx;
    logic [3:0]            r_strb;
    logic [3:0]            w_strb_nx;
    logic                  r_write;
    logic                  w_write_nx;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] w_prdata_nx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_nx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nx;
    logic                  r_pready;
    logic                  w_pready_nx;
    logic                  r_pslverr;
    logic                  w_pslverr_nx;

    logic                  w_xfer;
    logic                  w_illegal;
    logic                  w_timeout;

    assign w_xfer = PSEL & PENABLE;

    // TX data register is write-only and RX data register is read-only
    assign w_illegal = (PWRITE && (PADDR == RX_ADDR)) ||
                       (!PWRITE && (PADDR == TX_ADDR));

`ifdef APB_UART_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    // Held at zero outside BUSY, so it restarts from zero on every BUSY entry
    always_ff @(posedge PCLK) begin
        if (PRESET || (r_state != S_BUSY)) begin
            r_tmo_cnt <= 16'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT_CYCLES));
`else
    // Without the watchdog the limit has no effect; BUSY waits forever
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_nx   = r_state;
        w_strb_nx    = r_strb;
        w_write_nx   = r_write;
        w_addr_nx    = r_addr;
        w_wdata_nx   = r_wdata;
        w_prdata_nx  = '0;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_strb_nx = c_STB_NONE;
                if (w_xfer) begin
                    w_addr_nx  = PADDR;
                    w_wdata_nx = PWDATA;
                    w_write_nx = PWRITE;
                    if (w_illegal) begin
                        // Rejected without ever touching the core
                        w_pready_nx  = 1'b1;
                        w_pslverr_nx = 1'b1;
                        w_state_nx   = S_RESP;
                    end else begin
                        if (PWRITE) begin
                            w_strb_nx = (PADDR == TX_ADDR) ? c_STB_TX : c_STB_CW;
                        end else begin
                            w_strb_nx = (PADDR == RX_ADDR) ? c_STB_RX : c_STB_CR;
                        end
                        w_state_nx = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                // PSEL/PENABLE are deliberately ignored here: a started core
                // transfer always runs to completion.
                if (core_ready) begin
                    w_strb_nx    = c_STB_NONE;
                    w_pready_nx  = 1'b1;
                    w_prdata_nx  = r_write ? '0 : core_read_data;
                    w_pslverr_nx = core_error;
                    w_state_nx   = S_RESP;
                end else if (w_timeout) begin
                    w_strb_nx    = c_STB_NONE;
                    w_pready_nx  = 1'b1;
                    w_pslverr_nx = 1'b1;
                    w_state_nx   = S_RESP;
                end
            end

            S_RESP: begin
                w_strb_nx  = c_STB_NONE;
                w_state_nx = S_DRAIN;
            end

            S_DRAIN: begin
                // The core's done flag lags its strobe by a cycle; wait it out
                // so the next transfer does not see a stale ready.
                w_strb_nx = c_STB_NONE;
                if (!core_ready) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_strb_nx  = c_STB_NONE;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_strb    <= c_STB_NONE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_strb    <= w_strb_nx;
            r_write   <= w_write_nx;
            r_addr    <= w_addr_nx;
            r_wdata   <= w_wdata_nx;
            r_prdata  <= w_prdata_nx;
            r_pready  <= w_pready_nx;
            r_pslverr <= w_pslverr_nx;
        end
    end

    assign PRDATA              = r_prdata;
    assign PREADY              = r_pready;
    assign PSLVERR             = r_pslverr;
    assign write_data_in       = r_wdata;
    assign config_address      = r_addr;
    assign TX_detect           = r_strb[3];
    assign RX_detect           = r_strb[2];
    assign config_write_detect = r_strb[1];
    assign config_read_detect  = r_strb[0];

endmodule

`default_nettype wire

// File: tb/tb_apb_uart_slave_if.sv
`default_nettype none

//============================================================================
// Module      : tb_apb_uart_slave_if
// Description : Self-checking bench for apb_uart_slave_if. A small
//               behavioural core answers the strobes. Expected APB responses
//               are queued per transfer and compared when PREADY appears.
// Revision    : 1.0 - initial release
//============================================================================

module tb_apb_uart_slave_if;

    localparam int c_DW = 32;
    localparam int c_AW = 8;

    logic            PCLK;
    logic            PRESET;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [c_AW-1:0] PADDR;
    logic [c_DW-1:0] PWDATA;
    logic [c_DW-1:0] PRDATA;
    logic            PREADY;
    logic            PSLVERR;
    logic [c_DW-1:0] write_data_in;
    logic [c_AW-1:0] config_address;
    logic            TX_detect;
    logic            RX_detect;
    logic            config_write_detect;
    logic            config_read_detect;
    logic [c_DW-1:0] core_read_data;
    logic            core_ready;
    logic            core_error;

    apb_uart_slave_if #(
        .DATA_WIDTH     (c_DW),
        .ADDR_WIDTH     (c_AW),
        .TX_ADDR        (8'h00),
        .RX_ADDR        (8'h04),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK                (PCLK),
        .PRESET              (PRESET),
        .PSEL                (PSEL),
        .PENABLE             (PENABLE),
        .PWRITE              (PWRITE),
        .PADDR               (PADDR),
        .PWDATA              (PWDATA),
        .PRDATA              (PRDATA),
        .PREADY              (PREADY),
        .PSLVERR             (PSLVERR),
        .write_data_in       (write_data_in),
        .config_address      (config_address),
        .TX_detect           (TX_detect),
        .RX_detect           (RX_detect),
        .config_write_detect (config_write_detect),
        .config_read_detect  (config_read_detect),
        .core_read_data      (core_read_data),
        .core_ready          (core_ready),
        .core_error          (core_error)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural core: ready after core_lat strobe cycles, held while the
    // strobe is high, then for core_stretch extra cycles after it falls.
    // ------------------------------------------------------------------
    int              core_lat     = 1;
    int              core_stretch = 0;
    logic            core_err_inj = 1'b0;
    logic [c_DW-1:0] rx_byte      = 32'h3C;
    logic [c_DW-1:0] cfg_mem [0:255];
    int              m_cnt;
    int              m_str;
    logic            any_strb;

    assign any_strb = TX_detect | RX_detect | config_write_detect | config_read_detect;

    always @(posedge PCLK) begin
        if (PRESET) begin
            core_ready     <= 1'b0;
            core_error     <= 1'b0;
            core_read_data <= '0;
            m_cnt          <= 0;
            m_str          <= 0;
            for (int i = 0; i < 256; i++) cfg_mem[i] <= '0;
            cfg_mem[8'h0C] <= 32'd8;   // frame register reset value
        end else if (any_strb) begin
            if (m_cnt + 1 >= core_lat) core_ready <= 1'b1;
            m_cnt      <= m_cnt + 1;
            m_str      <= core_stretch;
            core_error <= core_err_inj;
            core_read_data <= RX_detect ? rx_byte :
                              (config_read_detect ? cfg_mem[config_address] : 32'hBAD0_BAD0);
            if (config_write_detect) cfg_mem[config_address] <= write_data_in;
        end else begin
            m_cnt <= 0;
            if (core_ready && (m_str != 0)) m_str <= m_str - 1;
            else core_ready <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [c_DW-1:0] rd;
        logic            err;
    } exp_t;

    exp_t       sb[$];
    int         strobe_cycles;
    logic [3:0] seen_strobes;

    always @(negedge PCLK) begin
        if (any_strb) begin
            strobe_cycles++;
            seen_strobes |= {TX_detect, RX_detect, config_write_detect, config_read_detect};
        end
        if (!PRESET && PREADY) begin
            exp_t e;
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("PRDATA", PRDATA, e.rd);
                chk("PSLVERR", PSLVERR, e.err);
                chk("strobes_in_resp",
                    {TX_detect, RX_detect, config_write_detect, config_read_detect}, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // APB master helpers
    // ------------------------------------------------------------------
    task automatic wait_pready(input string nm);
        int n = 0;
        while (!PREADY && n < 1000) begin
            @(negedge PCLK);
            n++;
        end
        chk(nm, PREADY, 1);
    endtask

    task automatic apb_xfer(input logic w, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        wait_pready("pready_timeout");
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    typedef struct {
        logic            w;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] wdata;
        int              lat;
        logic            cerr;
        logic [c_DW-1:0] exp_rd;
        logic            exp_err;
        logic [3:0]      exp_strb;   // {TX, RX, CW, CR}
        int              exp_cyc;
    } vec_t;

    localparam int c_NV = 9;
    vec_t vec [c_NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b0, 8'h0C, 32'h0,      1, 1'b0, 32'd8,     1'b0, 4'b0001, 2}; // frame read after reset
        vec[1] = '{1'b1, 8'h08, 32'h1C200,  1, 1'b0, 32'h0,     1'b0, 4'b0010, 2}; // baud write 115200
        vec[2] = '{1'b0, 8'h08, 32'h0,      1, 1'b0, 32'h1C200, 1'b0, 4'b0001, 2}; // baud readback
        vec[3] = '{1'b0, 8'h00, 32'h0,      1, 1'b0, 32'h0,     1'b1, 4'b0000, 0}; // read of TX: illegal
        vec[4] = '{1'b1, 8'h04, 32'h55,     1, 1'b0, 32'h0,     1'b1, 4'b0000, 0}; // write to RX: illegal
        vec[5] = '{1'b1, 8'h00, 32'hA5,     6, 1'b0, 32'h0,     1'b0, 4'b1000, 7}; // TX byte, slow core
        vec[6] = '{1'b0, 8'h04, 32'h0,      4, 1'b0, 32'h3C,    1'b0, 4'b0100, 5}; // RX byte
        vec[7] = '{1'b1, 8'h10, 32'hDEAD,   1, 1'b1, 32'h0,     1'b1, 4'b0010, 2}; // core error on write
        vec[8] = '{1'b0, 8'h10, 32'h0,      2, 1'b0, 32'hDEAD,  1'b0, 4'b0001, 3}; // config read

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        strobe_cycles = 0; seen_strobes = '0;

        // Reset values
        repeat (3) @(negedge PCLK);
        chk("reset_apb", {PRDATA, PREADY, PSLVERR}, 0);
        chk("reset_core_if", {write_data_in, config_address,
                              TX_detect, RX_detect, config_write_detect, config_read_detect}, 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Table-driven transfers
        for (int i = 0; i < c_NV; i++) begin
            core_lat      = vec[i].lat;
            core_err_inj  = vec[i].cerr;
            strobe_cycles = 0;
            seen_strobes  = '0;
            sb.push_back('{rd: vec[i].exp_rd, err: vec[i].exp_err});
            apb_xfer(vec[i].w, vec[i].addr, vec[i].wdata);
            chk("strobe_select", seen_strobes, vec[i].exp_strb);
            chk("strobe_cycles", strobe_cycles, vec[i].exp_cyc);
            chk("config_address", config_address, vec[i].addr);
            chk("write_data_in", write_data_in, vec[i].wdata);
        end
        core_err_inj = 1'b0;

        // Cycle-exact config write, then a second write held off by a
        // core_ready that lingers three extra cycles into DRAIN.
        core_lat = 1; core_stretch = 3;
        sb.push_back('{rd: 32'h0, err: 1'b0});
        sb.push_back('{rd: 32'h0, err: 1'b0});
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h1C200; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;                                              // cycle N
        @(negedge PCLK); chk("cw_at_N", config_write_detect, 0);
        @(negedge PCLK); chk("cw_at_N1", config_write_detect, 1);
        @(negedge PCLK); chk("cw_at_N2", {config_write_detect, PREADY}, 2'b10);
        @(negedge PCLK); chk("pready_at_N3", {PREADY, PSLVERR, config_write_detect}, 3'b100);
        @(posedge PCLK); #1;
        PENABLE = 1'b0; PWDATA = 32'h4B0;                            // N+4 setup
        @(negedge PCLK); chk("drain_N4", {PREADY, any_strb}, 0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;                                              // N+5
        for (int k = 5; k <= 8; k++) begin
            @(negedge PCLK);
            chk("held_off", {PREADY, any_strb}, 0);
        end
        core_stretch = 0;
        @(negedge PCLK); chk("second_accept_N9", config_write_detect, 1);
        wait_pready("b2b_pready_timeout");
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("b2b_wdata", write_data_in, 32'h4B0);

        // Reset while BUSY on a TX write the core never finishes
        core_lat = 32'h7FFF;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hA5; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;                                              // N
        @(negedge PCLK);
        @(negedge PCLK);                                             // N+1
        chk("busy_tx", {TX_detect, write_data_in}, {1'b1, 32'hA5});
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("busy_reset_apb", {PRDATA, PREADY, PSLVERR}, 0);
        chk("busy_reset_core_if", {write_data_in, config_address,
                                   TX_detect, RX_detect, config_write_detect, config_read_detect}, 0);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);

`ifdef APB_UART_TIMEOUT_EN
        // Watchdog: the core never answers, PSLVERR must arrive at N+18
        sb.push_back('{rd: 32'h0, err: 1'b1});
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 8'h0C; PWDATA = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;                                              // N
        for (int k = 0; k <= 17; k++) begin
            @(negedge PCLK);
            chk("tmo_wait", PREADY, 0);
        end
        @(negedge PCLK);                                             // N+18
        chk("tmo_resp", {PREADY, PSLVERR, config_read_detect}, 3'b110);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(negedge PCLK);
`endif

        repeat (4) @(negedge PCLK);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
